// File: rtl/scan_chain_loader.sv
// Purpose: byte-to-serial scan controller feeding memory_bank; returns the bits shifted out of the chain as bytes.
// Latency: byte accepted at edge k, scan_enable high for the next 8 cycles, out_valid from cycle k+9; full load NBYTES*10+1 cycles.
// Backpressure: in_valid low in LOAD or out_ready low in EMIT stalls with scan_enable low, so the chain is never disturbed.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start               one-cycle request to begin a full chain load (ignored unless idle)
//   busy, done          busy outside IDLE; done pulses once when the last byte has been returned
//   in_data/valid/ready byte stream shifted into the chain, MSB first
//   out_data/valid/ready bytes captured from chain_scan_out, same order as loaded
//   scan_enable, scan_in, chain_scan_out   serial interface to memory_bank
//   parity              only with SCAN_PARITY_EN defined: running XOR of every bit driven on scan_in,
//                       cleared on start, final once done pulses
module scan_chain_loader #(
  parameter int CHAIN_LEN = 272,
  parameter int BCNT_W    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       chain_scan_out
`ifdef SCAN_PARITY_EN
  ,
  output logic       parity
`endif
);

  localparam int NBYTES = CHAIN_LEN / 8;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        sh_q, sh_d;
  logic [7:0]        cap_q, cap_d;
`ifdef SCAN_PARITY_EN
  logic              parity_q, parity_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      cap_q      <= '0;
`ifdef SCAN_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      cap_q      <= cap_d;
`ifdef SCAN_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    cap_d       = cap_q;
`ifdef SCAN_PARITY_EN
    parity_d    = parity_q;
`endif
    busy        = (state_q != IDLE);
    done        = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    scan_enable = 1'b0;
    scan_in     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          byte_cnt_d = '0;
`ifdef SCAN_PARITY_EN
          parity_d   = 1'b0;
`endif
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sh_d      = in_data;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // scan_in and chain_scan_out move on the same edge, so cap collects
        // the old chain bit that the new bit displaces.
        scan_enable = 1'b1;
        scan_in     = sh_q[7];
        sh_d        = {sh_q[6:0], 1'b0};
        cap_d       = {cap_q[6:0], chain_scan_out};
        bit_cnt_d   = bit_cnt_q + 3'd1;
`ifdef SCAN_PARITY_EN
        parity_d    = parity_q ^ sh_q[7];
`endif
        if (bit_cnt_q == 3'd7) begin
          state_d = EMIT;
        end
      end

      EMIT: begin
        // cap is frozen here, which keeps out_data stable until accepted.
        out_valid = 1'b1;
        out_data  = cap_q;
        if (out_ready) begin
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = DONE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = LOAD;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SCAN_PARITY_EN
  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// Purpose: self-checking bench for scan_chain_loader against a behavioural scan chain.
// Latency: expected captured bytes are queued when each input byte is driven and compared as they emerge.
// Backpressure: the output monitor owns out_ready and can hold it low for a configured stall.
module tb_scan_chain_loader;

  localparam int CHAIN_LEN = 272;
  localparam int NBYTES    = CHAIN_LEN / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       busy, done, in_ready, out_valid, scan_enable, scan_in;
  logic [7:0] out_data;
  logic       chain_scan_out;
`ifdef SCAN_PARITY_EN
  logic       parity;
`endif

  // Behavioural memory_bank chain: scan_in enters at bit 0, scan_out leaves from the top.
  logic [CHAIN_LEN-1:0] chain = '0;
  assign chain_scan_out = chain[CHAIN_LEN-1];
  always @(posedge clk) if (scan_enable) chain <= {chain[CHAIN_LEN-2:0], scan_in};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always #5 clk = ~clk;

  scan_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .BCNT_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .scan_enable    (scan_enable),
    .scan_in        (scan_in),
    .chain_scan_out (chain_scan_out)
`ifdef SCAN_PARITY_EN
    ,
    .parity         (parity)
`endif
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_prev [NBYTES];
  logic [7:0] load_dat [NBYTES];
  int         done_cnt = 0;
  int         busy_cyc = 0;
  int         stall_gen = 0;   // written by main: bump to request one output stall
  int         stall_done = 0;  // written by monitor
  int         stall_left = 0;
  logic [7:0] held = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor / consumer.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rdy_vld_excl", {31'd0, in_ready & out_valid}, 32'd0);
        if (done) done_cnt++;
        if (busy) busy_cyc++;
        if (out_valid) begin
          if (out_ready && stall_gen != stall_done) begin
            out_ready  = 1'b0;
            stall_done = stall_gen;
            stall_left = 7;
            held       = out_data;
          end else begin
            if (!out_ready) begin
              chk("stall_se", {31'd0, scan_enable}, 32'd0);
              chk("stall_dat", {24'd0, out_data}, {24'd0, held});
              stall_left--;
              if (stall_left == 0) out_ready = 1'b1;
            end
            if (out_ready) begin
              if (exp_q.size() == 0) begin
                chk("unexp_out", {24'd0, out_data}, 32'hFFFF_FFFF);
              end else begin
                e = exp_q.pop_front();
                chk("out_dat", {24'd0, out_data}, {24'd0, e});
              end
            end
          end
        end
      end
    end
  end

  task automatic run_load(input int in_stall, input int start_at, input bit chk_lat);
    int  b0, d0, c0, t;
    bit  tmo;
    @(posedge clk); #1;
    b0 = busy_cyc;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc;
    tmo = 1'b0;
    for (int j = 0; j < NBYTES && !tmo; j++) begin
      if (j == 0 && in_stall > 0) begin
        repeat (in_stall) begin
          @(negedge clk);
          chk("in_stall_se", {31'd0, scan_enable}, 32'd0);
          chk("in_stall_rdy", {31'd0, in_ready}, 32'd1);
        end
        @(posedge clk); #1;
      end
      if (j == start_at) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      exp_q.push_back(exp_prev[j]);
      in_data  = load_dat[j];
      in_valid = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready && t < 100);
      if (!in_ready) begin
        chk("in_timeout", 32'd0, 32'd1);
        tmo = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    t = 0;
    while (!tmo) begin
      @(negedge clk);
      if (done) break;
      t++;
      if (t > 400) begin
        chk("done_timeout", 32'd0, 32'd1);
        tmo = 1'b1;
      end
    end
    // done is high in the cycle after edge start+NBYTES*10, busy for NBYTES*10+1 cycles.
    if (chk_lat) chk("done_lat", cyc - c0, NBYTES * 10);
    @(negedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("busy_end", {31'd0, busy}, 32'd0);
    if (chk_lat) chk("busy_len", busy_cyc - b0, NBYTES * 10 + 1);
    repeat (4) @(negedge clk);
    #1;
    chk("done_once", done_cnt - d0, 32'd1);
    chk("q_empty", exp_q.size(), 32'd0);
    for (int j = 0; j < NBYTES; j++) begin
      chk("chain_byte", {24'd0, chain[CHAIN_LEN-1-8*j -: 8]}, {24'd0, load_dat[j]});
      exp_prev[j] = load_dat[j];
    end
  endtask

  initial begin
    // Reset state.
    #1;
    chk("rst_outs", {16'd0, busy, done, in_ready, out_valid, scan_enable, scan_in, 2'b00, out_data}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_outs", {16'd0, busy, done, in_ready, out_valid, scan_enable, scan_in, 2'b00, out_data}, 32'd0);

    // 1: incrementing bytes into an empty chain.
    for (int j = 0; j < NBYTES; j++) begin
      exp_prev[j] = 8'h00;
      load_dat[j] = 8'(j);
    end
    run_load(0, -1, 1'b1);

    // 2: all-ones reads back the previous load in order.
    for (int j = 0; j < NBYTES; j++) load_dat[j] = 8'hFF;
    run_load(0, -1, 1'b1);
    chk("lock_key", {16'd0, chain[CHAIN_LEN-1 -: 16]}, 32'h0000_FFFF);

    // 3: input stall then output stall; chain must end identical to run 1.
    for (int j = 0; j < NBYTES; j++) load_dat[j] = 8'(j);
    stall_gen++;
    run_load(5, -1, 1'b0);

    // 4: start pulsed mid-load is ignored.
    for (int j = 0; j < NBYTES; j++) load_dat[j] = 8'(j * 7 + 3);
    run_load(0, 10, 1'b0);

    // 5: reset during the shift of 0x5A.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_data  = 8'h5A;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("se_shift", {31'd0, scan_enable}, 32'd1);
    rst = 1'b0;
    #1;
    chk("se_async", {31'd0, scan_enable}, 32'd0);
    chk("rst_mid_outs", {16'd0, busy, done, in_ready, out_valid, scan_enable, scan_in, 2'b00, out_data}, 32'd0);
    chk("chain_partial", {29'd0, chain[2:0]}, 32'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_outs", {16'd0, busy, done, in_ready, out_valid, scan_enable, scan_in, 2'b00, out_data}, 32'd0);

`ifdef SCAN_PARITY_EN
    // 6: a single set bit across the whole load gives odd parity.
    for (int j = 0; j < NBYTES; j++) begin
      exp_prev[j] = chain[CHAIN_LEN-1-8*j -: 8];
      load_dat[j] = (j == NBYTES - 1) ? 8'h01 : 8'h00;
    end
    run_load(0, -1, 1'b1);
    chk("parity", {31'd0, parity}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
